vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the successor to the fixed 800x600 controller. It adds configurable porch, sync and display widths, programmable sync polarity, a pixel clock-enable for running off a faster system clock, and a run/stop control. It also provides line-start and frame-start strobes for the frame-buffer fetch logic. It sits between the pixel-clock domain and the DAC/pixel pipeline: `nextX`/`nextY` feed the pixel source, and the registered sync/blank outputs go to the DAC.

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running h/v counters with
// combinational next-pixel address and registered sync/blank/strobe outputs.
module vga_timing_gen #(
  parameter int H_DISPLAY = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_DISPLAY = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enable,
  input  logic           PixelEn,
  output logic [X_W-1:0] nextX,
  output logic [Y_W-1:0] nextY,
  output logic           nextValid,
  output logic           blank_n,
  output logic           hSync,
  output logic           vSync,
  output logic           sync_n,
  output logic           lineStart,
  output logic           frameStart
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_W-1:0] H_MAX = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_TOTAL - 1);

  // Decode bounds kept 32 bits wide so a sync end equal to 2^X_W cannot wrap.
  localparam logic [31:0] H_ACT_END = 32'(H_DISPLAY);
  localparam logic [31:0] H_SYNC_LO = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] H_SYNC_HI = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_DISPLAY);
  localparam logic [31:0] V_SYNC_LO = 32'(V_DISPLAY + V_FRONT);
  localparam logic [31:0] V_SYNC_HI = 32'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  logic [X_W-1:0] h_count, h_next;
  logic [Y_W-1:0] v_count, v_next;
  logic [31:0]    h_ext, v_ext;
  logic           active, h_act, v_act;

  always_comb begin
    h_ext  = 32'(h_count);
    v_ext  = 32'(v_count);
    active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    h_act  = (h_ext >= H_SYNC_LO) && (h_ext < H_SYNC_HI);
    v_act  = (v_ext >= V_SYNC_LO) && (v_ext < V_SYNC_HI);

    h_next = h_count + 1'b1;
    v_next = v_count;
    if (h_count == H_MAX) begin
      h_next = '0;
      v_next = (v_count == V_MAX) ? '0 : v_count + 1'b1;
    end
  end

  assign nextX     = active ? h_count : '0;
  assign nextY     = active ? v_count : '0;
  assign nextValid = active;

  // Enable low parks the raster at (0,0) with idle outputs; it outranks a tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      h_count    <= '0;
      v_count    <= '0;
      blank_n    <= 1'b0;
      hSync      <= ~HS_ON;
      vSync      <= ~VS_ON;
      sync_n     <= 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (!Enable) begin
      h_count    <= '0;
      v_count    <= '0;
      blank_n    <= 1'b0;
      hSync      <= ~HS_ON;
      vSync      <= ~VS_ON;
      sync_n     <= 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (PixelEn) begin
      h_count    <= h_next;
      v_count    <= v_next;
      blank_n    <= active;
      hSync      <= h_act ? HS_ON : ~HS_ON;
      vSync      <= v_act ? VS_ON : ~VS_ON;
      sync_n     <= ~(h_act || v_act);
      lineStart  <= (h_count == '0);
      frameStart <= (h_count == '0) && (v_count == '0);
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster (14x7) with mixed
// sync polarities, using a linear-position reference model.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic       Clock = 1'b0;
  logic       Reset, Enable, PixelEn;
  logic [3:0] nextX;
  logic [2:0] nextY;
  logic       nextValid, blank_n, hSync, vSync, sync_n, lineStart, frameStart;

  int total = 0;
  int bad   = 0;

  // Model: raster position as a linear index into the frame, plus the
  // expected registered outputs.
  int   pos;
  logic mBlank, mHs, mVs, mSyncN, mLine, mFrame;

  typedef struct {
    logic en;
    logic pe;
    int   x;
    logic valid;
    logic blank;
    logic line;
    logic frame;
  } vec_t;

  vec_t vecs[6];

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1), .VSYNC_POL(0), .X_W(4), .Y_W(3)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .PixelEn(PixelEn),
    .nextX(nextX), .nextY(nextY), .nextValid(nextValid),
    .blank_n(blank_n), .hSync(hSync), .vSync(vSync), .sync_n(sync_n),
    .lineStart(lineStart), .frameStart(frameStart)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelIdle();
    mBlank = 1'b0;
    mHs    = 1'b0;
    mVs    = 1'b1;
    mSyncN = 1'b1;
    mLine  = 1'b0;
    mFrame = 1'b0;
  endtask

  task automatic modelClock(input logic en, input logic pe);
    int h, v;
    logic hact, vact;
    if (!en) begin
      pos = 0;
      modelIdle();
    end else if (pe) begin
      h      = pos % HT;
      v      = pos / HT;
      hact   = (h >= HD + HF) && (h < HD + HF + HS);
      vact   = (v >= VD + VF) && (v < VD + VF + VS);
      mBlank = (h < HD) && (v < VD);
      mHs    = hact;
      mVs    = !vact;
      mSyncN = !(hact || vact);
      mLine  = (h == 0);
      mFrame = (pos == 0);
      pos    = (pos + 1) % (HT * VT);
    end else begin
      mLine  = 1'b0;
      mFrame = 1'b0;
    end
  endtask

  task automatic checkAll();
    int h, v;
    logic act;
    h   = pos % HT;
    v   = pos / HT;
    act = (h < HD) && (v < VD);
    checkOutput("nextX", nextX, act ? h : 0);
    checkOutput("nextY", nextY, act ? v : 0);
    checkOutput("nextValid", nextValid, act);
    checkOutput("blank_n", blank_n, mBlank);
    checkOutput("hSync", hSync, mHs);
    checkOutput("vSync", vSync, mVs);
    checkOutput("sync_n", sync_n, mSyncN);
    checkOutput("lineStart", lineStart, mLine);
    checkOutput("frameStart", frameStart, mFrame);
  endtask

  task automatic applyStimulus(input logic en, input logic pe);
    @(negedge Clock);
    Enable  = en;
    PixelEn = pe;
    @(posedge Clock);
    modelClock(en, pe);
    #1;
  endtask

  initial begin
    int lastLine, lastFrame, nLines, nFrames;

    vecs[0] = '{en: 1, pe: 1, x: 1, valid: 1, blank: 1, line: 1, frame: 1};
    vecs[1] = '{en: 1, pe: 0, x: 1, valid: 1, blank: 1, line: 0, frame: 0};
    vecs[2] = '{en: 1, pe: 1, x: 2, valid: 1, blank: 1, line: 0, frame: 0};
    vecs[3] = '{en: 0, pe: 1, x: 0, valid: 1, blank: 0, line: 0, frame: 0};
    vecs[4] = '{en: 1, pe: 0, x: 0, valid: 1, blank: 0, line: 0, frame: 0};
    vecs[5] = '{en: 1, pe: 1, x: 1, valid: 1, blank: 1, line: 1, frame: 1};

    Reset   = 1'b1;
    Enable  = 1'b0;
    PixelEn = 1'b0;
    pos     = 0;
    modelIdle();
    #2;
    checkAll();
    @(negedge Clock);
    Reset = 1'b0;

    // Hand-computed vectors straight out of reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].en, vecs[i].pe);
      checkOutput("vecX", nextX, vecs[i].x);
      checkOutput("vecValid", nextValid, vecs[i].valid);
      checkOutput("vecBlank", blank_n, vecs[i].blank);
      checkOutput("vecLine", lineStart, vecs[i].line);
      checkOutput("vecFrame", frameStart, vecs[i].frame);
    end

    // Free-running periods from a parked raster.
    applyStimulus(1'b0, 1'b1);
    lastLine = -1; lastFrame = -1; nLines = 0; nFrames = 0;
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, 1'b1);
      checkAll();
      if (lineStart) begin
        if (lastLine >= 0) checkOutput("linePeriod", c - lastLine, HT);
        lastLine = c;
        nLines++;
      end
      if (frameStart) begin
        if (lastFrame >= 0) checkOutput("framePeriod", c - lastFrame, HT * VT);
        lastFrame = c;
        nFrames++;
      end
    end
    checkOutput("lineCount", nLines, 15);
    checkOutput("frameCount", nFrames, 3);

    // PixelEn every other cycle doubles the line period.
    applyStimulus(1'b0, 1'b1);
    lastLine = -1; nLines = 0;
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, (c % 2) == 0);
      checkAll();
      if (lineStart) begin
        if (lastLine >= 0) checkOutput("halfRateLinePeriod", c - lastLine, 2 * HT);
        lastLine = c;
        nLines++;
      end
    end
    checkOutput("halfRateLineCount", nLines, 8);

    // Enable dropped at (5,2) for three cycles.
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 2 * HT + 5; c++) applyStimulus(1'b1, 1'b1);
    checkOutput("dropX", nextX, 5);
    checkOutput("dropY", nextY, 2);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1);
      checkAll();
      checkOutput("parkBlank", blank_n, 0);
      checkOutput("parkSyncN", sync_n, 1);
      checkOutput("parkX", nextX, 0);
    end
    applyStimulus(1'b1, 1'b1);
    checkAll();
    checkOutput("resumeFrame", frameStart, 1);
    checkOutput("resumeX", nextX, 1);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0);
      checkAll();
    end

    // Asynchronous reset mid-line.
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    pos = 0;
    modelIdle();
    checkAll();
    @(negedge Clock);
    Reset   = 1'b0;
    Enable  = 1'b1;
    PixelEn = 1'b1;
    @(posedge Clock);
    modelClock(1'b1, 1'b1);
    #1;
    checkAll();
    checkOutput("frameAfterReset", frameStart, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
